// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcodes, ALUOp codes, control-FSM states and control word
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    EXEC      = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;
endpackage

// File: rtl/mc_main_control.sv
// mc_main_control: multicycle MIPS32 main control Moore FSM with mem_ready handshake
module mc_main_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op
);
  state_t state, next;
  ctrl_t  c;
  always_ff @(posedge clk)
    state <= reset ? FETCH : next;
  always_comb begin
    c    = '0;
    next = FETCH;
    case (state)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALUOP_ADD;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
        next        = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALUOP_ADD;
        case (opcode)
          OP_RTYPE:     next = EXEC;
          OP_LW, OP_SW: next = MEM_ADDR;
          OP_BEQ:       next = BRANCH;
          OP_J:         next = JUMP;
          OP_ADDI:      next = ADDI_EXEC;
          default:      c.illegal_op = 1'b1;
        endcase
      end
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALUOP_ADD;
        next        = opcode == OP_SW ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
        next       = mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      MEM_WR: begin
        c.mem_write  = 1'b1;
        c.i_or_d     = 1'b1;
        c.instr_done = mem_ready;
        next         = mem_ready ? FETCH : MEM_WR;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
        next        = R_WB;
      end
      R_WB: begin
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.instr_done    = 1'b1;
      end
      JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = 2'b10;
        c.instr_done = 1'b1;
      end
      ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALUOP_ADD;
        next        = ADDI_WB;
      end
      ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      default: next = FETCH;
    endcase
  end
  assign {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
          RegWrite, RegDst, ALUSrcB, PCSource, ALUOp, instr_done, illegal_op} = reset ? '0 : c;
endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: directed per-scenario checks of the multicycle control FSM outputs
module tb_mc_main_control;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic       instr_done, illegal_op;
  logic [17:0] ctrl;
  int compared = 0;
  int mismatched = 0;
  typedef struct {
    logic        rst;
    logic        mr;
    logic [17:0] e;
  } vec_t;
  mc_main_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .instr_done(instr_done), .illegal_op(illegal_op)
  );
  always #5 clk = ~clk;
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
                 RegWrite, RegDst, ALUSrcB, PCSource, ALUOp, instr_done, illegal_op};
  function automatic logic [17:0] pk(input logic pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd,
                                     input logic [1:0] asb, pcs, aop, input logic done, ill);
    return {pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, asb, pcs, aop, done, ill};
  endfunction
  localparam logic [17:0] E_ZERO    = 18'd0;
  localparam logic [17:0] E_FETCH_R = pk(1,0,0,1,0,0,1,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
  localparam logic [17:0] E_FETCH_W = pk(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
  localparam logic [17:0] E_DECODE  = pk(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,0);
  localparam logic [17:0] E_ILL     = pk(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,1);
  localparam logic [17:0] E_MADDR   = pk(0,0,0,0,0,0,0,1,0,0, 2'b10, 2'b00, 2'b00, 0,0);
  localparam logic [17:0] E_MRD     = pk(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
  localparam logic [17:0] E_MWB     = pk(0,0,0,0,0,1,0,0,1,0, 2'b00, 2'b00, 2'b00, 1,0);
  localparam logic [17:0] E_MWR_W   = pk(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
  localparam logic [17:0] E_MWR_R   = pk(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1,0);
  localparam logic [17:0] E_EXEC    = pk(0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 2'b10, 0,0);
  localparam logic [17:0] E_RWB     = pk(0,0,0,0,0,0,0,0,1,1, 2'b00, 2'b00, 2'b00, 1,0);
  localparam logic [17:0] E_BR      = pk(0,1,0,0,0,0,0,1,0,0, 2'b00, 2'b01, 2'b01, 1,0);
  localparam logic [17:0] E_J       = pk(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 1,0);
  localparam logic [17:0] E_AWB     = pk(0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 1,0);
  task automatic test_reset();
    vec_t v[$] = '{'{1,1,E_ZERO}, '{1,0,E_ZERO}, '{1,1,E_ZERO}, '{0,0,E_FETCH_W}, '{0,0,E_FETCH_W}};
    foreach (v[i]) begin
      @(negedge clk);
      reset = v[i].rst; mem_ready = v[i].mr;
      #1;
      compared++;
      if (ctrl !== v[i].e) begin
        mismatched++;
        $display("FAIL reset[%0d]: got %b want %b", i, ctrl, v[i].e);
      end
    end
  endtask
  task automatic test_rtype();
    vec_t v[$] = '{'{0,0,E_FETCH_W}, '{0,1,E_FETCH_R}, '{0,1,E_DECODE}, '{0,1,E_EXEC}, '{0,1,E_RWB}};
    opcode = 6'b000000;
    foreach (v[i]) begin
      @(negedge clk);
      reset = v[i].rst; mem_ready = v[i].mr;
      #1;
      compared++;
      if (ctrl !== v[i].e) begin
        mismatched++;
        $display("FAIL rtype[%0d]: got %b want %b", i, ctrl, v[i].e);
      end
    end
  endtask
  task automatic test_lw();
    vec_t v[$] = '{'{0,1,E_FETCH_R}, '{0,1,E_DECODE}, '{0,1,E_MADDR}, '{0,0,E_MRD},
                   '{0,0,E_MRD}, '{0,1,E_MRD}, '{0,1,E_MWB}};
    opcode = 6'b100011;
    foreach (v[i]) begin
      @(negedge clk);
      reset = v[i].rst; mem_ready = v[i].mr;
      #1;
      compared++;
      if (ctrl !== v[i].e) begin
        mismatched++;
        $display("FAIL lw[%0d]: got %b want %b", i, ctrl, v[i].e);
      end
    end
  endtask
  task automatic test_sw_addi();
    vec_t v[$] = '{'{0,1,E_FETCH_R}, '{0,1,E_DECODE}, '{0,1,E_MADDR}, '{0,0,E_MWR_W}, '{0,1,E_MWR_R},
                   '{0,1,E_FETCH_R}, '{0,1,E_DECODE}, '{0,1,E_MADDR}, '{0,1,E_AWB}};
    foreach (v[i]) begin
      @(negedge clk);
      opcode = i < 5 ? 6'b101011 : 6'b001000;
      reset = v[i].rst; mem_ready = v[i].mr;
      #1;
      compared++;
      if (ctrl !== v[i].e) begin
        mismatched++;
        $display("FAIL sw_addi[%0d]: got %b want %b", i, ctrl, v[i].e);
      end
    end
  endtask
  task automatic test_back_to_back();
    vec_t v[$] = '{'{0,1,E_FETCH_R}, '{0,1,E_DECODE}, '{0,1,E_BR},
                   '{0,1,E_FETCH_R}, '{0,1,E_DECODE}, '{0,1,E_J}};
    foreach (v[i]) begin
      @(negedge clk);
      opcode = i < 3 ? 6'b000100 : 6'b000010;
      reset = v[i].rst; mem_ready = v[i].mr;
      #1;
      compared++;
      if (ctrl !== v[i].e) begin
        mismatched++;
        $display("FAIL beq_j[%0d]: got %b want %b", i, ctrl, v[i].e);
      end
    end
  endtask
  task automatic test_illegal();
    vec_t v[$] = '{'{0,1,E_FETCH_R}, '{0,1,E_ILL}, '{0,0,E_FETCH_W}, '{0,0,E_FETCH_W}};
    opcode = 6'b111111;
    foreach (v[i]) begin
      @(negedge clk);
      reset = v[i].rst; mem_ready = v[i].mr;
      #1;
      compared++;
      if (ctrl !== v[i].e) begin
        mismatched++;
        $display("FAIL illegal[%0d]: got %b want %b", i, ctrl, v[i].e);
      end
    end
  endtask
  task automatic test_reset_store();
    vec_t v[$] = '{'{0,1,E_FETCH_R}, '{0,1,E_DECODE}, '{0,1,E_MADDR}, '{0,0,E_MWR_W},
                   '{1,0,E_ZERO}, '{0,0,E_FETCH_W}, '{0,1,E_FETCH_R}};
    opcode = 6'b101011;
    foreach (v[i]) begin
      @(negedge clk);
      reset = v[i].rst; mem_ready = v[i].mr;
      #1;
      compared++;
      if (ctrl !== v[i].e) begin
        mismatched++;
        $display("FAIL reset_store[%0d]: got %b want %b", i, ctrl, v[i].e);
      end
    end
  endtask
  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_sw_addi();
    test_back_to_back();
    test_illegal();
    test_reset_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mc_main_control.md
# mc_main_control

Multicycle MIPS32 main control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several clock cycles. It drives datapath enables and mux selects, and supplies the 2-bit `ALUOp` consumed by the ALU control stage directly downstream. Memory accesses wait on a `mem_ready` handshake.

## Interface
Parameters:
- none; opcodes and encodings are fixed constants in the shared package.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  6  instruction[31:26] from the instruction register (IR).
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst`  out  1 each  datapath controls.
- `ALUSrcB`  out  2  ALU B-input select: 00 = reg, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `PCSource`  out  2  PC next-value select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `ALUOp`  out  2  ALU function: 00 = add, 01 = sub, 10 = decode funct field.
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction.
- `illegal_op`  out  1  one-cycle pulse when decode sees an unsupported opcode.

## Operation
State register is 4 bits wide. Output defaults: every output not listed for a state is 0.

- **FETCH**: `MemRead`=1; `ALUSrcB`=01; `ALUOp`=00. `IRWrite` and `PCWrite` are driven equal to `mem_ready`. Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- **DECODE**: `ALUSrcB`=11; `ALUOp`=00 (precomputes the branch target). Next state by opcode:
  - 000000 → EXEC
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDI_EXEC
  - any other opcode → FETCH, with `illegal_op`=1 for this cycle.
- **MEM_ADDR**: `ALUSrcA`=1; `ALUSrcB`=10; `ALUOp`=00. Go to MEM_RD for lw, MEM_WR for sw.
- **MEM_RD**: `MemRead`=1, `IorD`=1. Wait for `mem_ready`, then go to MEM_WB.
- **MEM_WB**: `MemtoReg`=1, `RegWrite`=1, `instr_done`=1. Go to FETCH.
- **MEM_WR**: `MemWrite`=1, `IorD`=1. Wait for `mem_ready`; on the `mem_ready` cycle `instr_done`=1, then go to FETCH.
- **EXEC**: `ALUSrcA`=1; `ALUSrcB`=00; `ALUOp`=10. Go to R_WB.
- **R_WB**: `RegDst`=1, `RegWrite`=1, `instr_done`=1. Go to FETCH.
- **BRANCH**: `ALUSrcA`=1; `ALUOp`=01; `PCWriteCond`=1; `PCSource`=01; `instr_done`=1. Go to FETCH.
- **JUMP**: `PCWrite`=1; `PCSource`=10; `instr_done`=1. Go to FETCH.
- **ADDI_EXEC**: `ALUSrcA`=1; `ALUSrcB`=10; `ALUOp`=00. Go to ADDI_WB.
- **ADDI_WB**: `RegWrite`=1, `instr_done`=1. Go to FETCH.
- **Unused state encodings**: all outputs 0; next state FETCH.

`opcode` is sampled only in DECODE and MEM_ADDR. The IR is stable in those states because `IRWrite` is asserted only in FETCH.

## Timing
- **Reset**: while `reset`=1, every output is forced to 0 combinationally. The next state is FETCH. The first cycle after `reset` deasserts is FETCH.
- **Reset mid-instruction**: the instruction is abandoned and no further write enables are issued. This includes aborting a pending MEM_WR.
- **Cycles per instruction** with `mem_ready` always 1: R-type 4, lw 5, sw 4, addi 4, beq 3, j 3.
- **Memory wait**: each `mem_ready`=0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Outputs are held constant during the wait, except the `mem_ready`-qualified `IRWrite`, `PCWrite` and `instr_done`.
- **Illegal opcode**: takes 2 cycles (FETCH, DECODE) and returns to FETCH. `instr_done` is not asserted.

## Structure
- **Package `mips_ctrl_pkg`** holds:
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_ADDI`);
  - `ALUOp` constants (`ALUOP_ADD`=00, `ALUOP_SUB`=01, `ALUOP_FUNCT`=10);
  - the 4-bit state encodings.
- The ALU control stage shares the `ALUOp` constants from this package.
- **Implementation**: a single module with one registered state process and one combinational next-state/output process. No sub-module.

## Test plan
- **Reset**: `reset`=1 for 3 cycles → all outputs 0. First cycle after release: `MemRead`=1, `ALUSrcB`=01, `ALUOp`=00.
- **R-type**: `opcode`=000000 with `mem_ready`=1 → states FETCH, DECODE, EXEC, R_WB. `ALUOp`=10 in EXEC. `RegDst`=`RegWrite`=`instr_done`=1 in cycle 4.
- **lw**: `opcode`=100011 with `mem_ready` low for 2 cycles in MEM_RD → 7 cycles total. `IorD`=1 throughout MEM_RD. `MemtoReg`=`RegWrite`=1 in the last cycle.
- **beq then j**: `opcode`=000100, then `opcode`=000010 → BRANCH cycle shows `PCWriteCond`=1, `PCSource`=01, `ALUOp`=01. JUMP cycle shows `PCWrite`=1, `PCSource`=10. Each instruction takes 3 cycles.
- **Illegal opcode**: `opcode`=111111 → `illegal_op` pulses in DECODE. Back to FETCH the next cycle. No `RegWrite`, `MemWrite` or `instr_done`.
- **Reset during store**: assert `reset` during MEM_WR while `mem_ready`=0 → `MemWrite` drops to 0 in the same cycle. FETCH follows reset release.
